// File: rtl/pic_pkg.sv
// pic_pkg: shared states, strobe indices and register bit positions for the PIC bus interface
package pic_pkg;
  typedef enum logic [2:0] {S_INIT_WAIT, S_ICW2, S_ICW3, S_ICW4, S_READY} state_e;
  localparam int ICW1_I = 0;
  localparam int ICW2_I = 1;
  localparam int ICW3_I = 2;
  localparam int ICW4_I = 3;
  localparam int OCW1_I = 0;
  localparam int OCW2_I = 1;
  localparam int OCW3_I = 2;
  localparam logic RR_IRR = 1'b0;
  localparam logic RR_ISR = 1'b1;
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_SEL  = 3;
  localparam int OCW3_D7   = 7;
endpackage

// File: rtl/pic_strobe_sync.sv
// pic_strobe_sync: multi-flop synchroniser with change detect (rise = chg & lvl, fall = chg & ~lvl)
module pic_strobe_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic chg
);
  logic [STAGES:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {(STAGES+1){RST_VAL}};
    else sync_q <= {sync_q[STAGES-1:0], d};
  end
  assign lvl = sync_q[STAGES-1];
  assign chg = sync_q[STAGES-1] ^ sync_q[STAGES];
endmodule

// File: rtl/pic_bus_if.sv
// pic_bus_if: synchronised CPU read/write front end, ICW/OCW decode and read/vector data mux
module pic_bus_if
  import pic_pkg::*;
#(
  parameter int DW          = 8,
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             a0,
  input  logic [DW-1:0]    d_in,
  output logic [DW-1:0]    d_out,
  output logic             d_oe,
  input  logic [N_IRQ-1:0] irr,
  input  logic [N_IRQ-1:0] isr,
  input  logic [N_IRQ-1:0] imr,
  input  logic             vec_valid,
  input  logic [DW-1:0]    vec,
  output logic [3:0]       icw_stb,
  output logic [2:0]       ocw_stb,
  output logic [DW-1:0]    wdata,
  output logic             init_done,
  output logic             sngl,
  output logic             ic4,
  output logic             ltim
);
  logic cs_s, cs_c, rd_s, rd_c, wr_s, wr_c;
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (.clk(clk), .rst_n(rst_n), .d(cs_n), .lvl(cs_s), .chg(cs_c));
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd (.clk(clk), .rst_n(rst_n), .d(rd_n), .lvl(rd_s), .chg(rd_c));
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr (.clk(clk), .rst_n(rst_n), .d(wr_n), .lvl(wr_s), .chg(wr_c));
  logic [SYNC_STAGES-1:0]         a0_q;
  logic [SYNC_STAGES-1:0][DW-1:0] din_q;
  logic                           cap_a0_q;
  logic [DW-1:0]                  cap_d_q;
  logic                           a0_s;
  assign a0_s = a0_q[SYNC_STAGES-1];
  // a0 and data travel through the same depth as wr_n so the captured pair matches the last low wr_n sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q     <= '0;
      din_q    <= '0;
      cap_a0_q <= 1'b0;
      cap_d_q  <= '0;
    end else begin
      a0_q  <= {a0_q[SYNC_STAGES-2:0], a0};
      din_q <= {din_q[SYNC_STAGES-2:0], d_in};
      if (!wr_s) begin
        cap_a0_q <= a0_s;
        cap_d_q  <= din_q[SYNC_STAGES-1];
      end
    end
  end
  logic wr_acc, rd_act, rd_load;
  assign wr_acc  = wr_c & wr_s & ~cs_s & rd_s;
  assign rd_act  = ~rd_s & ~cs_s;
  state_e        state_q, state_d;
  logic [3:0]    icw_stb_q, icw_stb_d;
  logic [2:0]    ocw_stb_q, ocw_stb_d;
  logic [DW-1:0] wdata_q, wdata_d, d_out_q, d_out_d, rd_data;
  logic          init_done_q, init_done_d, sngl_q, sngl_d, ic4_q, ic4_d, ltim_q, ltim_d;
  logic          rr_sel_q, rr_sel_d, d_oe_q, d_oe_d, vec_q;
  assign rd_load = rd_act & ~vec_valid & ((rd_c & ~rd_s) | (cs_c & ~cs_s) | vec_q);
  always_comb begin
    state_d     = state_q;
    icw_stb_d   = '0;
    ocw_stb_d   = '0;
    wdata_d     = wdata_q;
    init_done_d = init_done_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    ltim_d      = ltim_q;
    rr_sel_d    = rr_sel_q;
    if (wr_acc) begin
      if (!cap_a0_q && cap_d_q[ICW1_SEL]) begin
        icw_stb_d[ICW1_I] = 1'b1;
        state_d           = S_ICW2;
        init_done_d       = 1'b0;
        rr_sel_d          = RR_IRR;
        sngl_d            = cap_d_q[ICW1_SNGL];
        ic4_d             = cap_d_q[ICW1_IC4];
        ltim_d            = cap_d_q[ICW1_LTIM];
      end else if (state_q == S_ICW2 && cap_a0_q) begin
        icw_stb_d[ICW2_I] = 1'b1;
        state_d           = !sngl_q ? S_ICW3 : ic4_q ? S_ICW4 : S_READY;
      end else if (state_q == S_ICW3 && cap_a0_q) begin
        icw_stb_d[ICW3_I] = 1'b1;
        state_d           = ic4_q ? S_ICW4 : S_READY;
      end else if (state_q == S_ICW4 && cap_a0_q) begin
        icw_stb_d[ICW4_I] = 1'b1;
        state_d           = S_READY;
      end else if (state_q == S_READY) begin
        if (cap_a0_q) ocw_stb_d[OCW1_I] = 1'b1;
        else if (!cap_d_q[OCW3_SEL]) ocw_stb_d[OCW2_I] = 1'b1;
        else if (!cap_d_q[OCW3_D7]) begin
          ocw_stb_d[OCW3_I] = 1'b1;
          rr_sel_d          = cap_d_q[OCW3_RR] ? cap_d_q[OCW3_RIS] : rr_sel_q;
        end
      end
    end
    wdata_d     = |{icw_stb_d, ocw_stb_d} ? cap_d_q : wdata_d;
    init_done_d = (state_d == S_READY && state_q != S_READY) ? 1'b1 : init_done_d;
  end
  always_comb begin
    rd_data = a0_s ? DW'(imr) : DW'(rr_sel_q ? isr : irr);
    d_oe_d  = vec_valid | rd_act;
    d_out_d = vec_valid ? vec : rd_load ? rd_data : d_out_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT_WAIT;
      icw_stb_q   <= '0;
      ocw_stb_q   <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
      sngl_q      <= 1'b1;
      ic4_q       <= 1'b0;
      ltim_q      <= 1'b0;
      rr_sel_q    <= RR_IRR;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      vec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      icw_stb_q   <= icw_stb_d;
      ocw_stb_q   <= ocw_stb_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      ltim_q      <= ltim_d;
      rr_sel_q    <= rr_sel_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      vec_q       <= vec_valid;
    end
  end
  assign icw_stb   = icw_stb_q;
  assign ocw_stb   = ocw_stb_q;
  assign wdata     = wdata_q;
  assign init_done = init_done_q;
  assign sngl      = sngl_q;
  assign ic4       = ic4_q;
  assign ltim      = ltim_q;
  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
endmodule

// File: tb/tb_pic_bus_if.sv
// tb_pic_bus_if: directed stimulus with a strobe/read scoreboard drained by an independent monitor
module tb_pic_bus_if;
  logic clk = 0, rst_n = 0, cs_n = 1, rd_n = 1, wr_n = 1, a0 = 0, vec_valid = 0;
  logic [7:0] d_in = 0, irr = 8'hA5, isr = 8'h3C, imr = 8'hF0, vec = 0;
  logic [7:0] d_out, wdata;
  logic [3:0] icw_stb;
  logic [2:0] ocw_stb;
  logic d_oe, init_done, sngl, ic4, ltim;
  int checks = 0, errors = 0, cyc = 0, rise_cyc = 0;
  typedef struct {logic [3:0] icw; logic [2:0] ocw; logic [7:0] d;} wexp_t;
  wexp_t wq[$];
  logic [7:0] rq[$];
  pic_bus_if #(.DW(8), .N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .irr(irr), .isr(isr), .imr(imr), .vec_valid(vec_valid), .vec(vec),
    .icw_stb(icw_stb), .ocw_stb(ocw_stb), .wdata(wdata), .init_done(init_done),
    .sngl(sngl), .ic4(ic4), .ltim(ltim));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_w(input logic [3:0] icw, input logic [2:0] ocw, input logic [7:0] d);
    wexp_t e;
    e.icw = icw; e.ocw = ocw; e.d = d;
    wq.push_back(e);
  endtask
  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk); cs_n = 0; a0 = a; d_in = d;
    repeat (2) @(negedge clk); wr_n = 0;
    repeat (3) @(negedge clk); wr_n = 1; rise_cyc = cyc;
    repeat (5) @(negedge clk); cs_n = 1;
    repeat (4) @(negedge clk);
  endtask
  task automatic rd(input logic a, input logic [7:0] exp);
    rq.push_back(exp);
    @(negedge clk); cs_n = 0; a0 = a;
    repeat (2) @(negedge clk); rd_n = 0;
    repeat (6) @(negedge clk);
    chk("rd_hold", d_out, exp);
    rd_n = 1;
    repeat (2) @(negedge clk); cs_n = 1;
    repeat (4) @(negedge clk);
    chk("rd_oe_off", d_oe, 0);
  endtask
  initial begin : monitor
    wexp_t e;
    logic oe_prev;
    oe_prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ({icw_stb, ocw_stb} != 0) begin
          chk("onehot", $onehot({icw_stb, ocw_stb}), 1);
          if (wq.size() == 0) chk("unexp_stb", {icw_stb, ocw_stb}, 0);
          else begin
            e = wq.pop_front();
            chk("icw_stb", icw_stb, e.icw);
            chk("ocw_stb", ocw_stb, e.ocw);
            chk("wdata", wdata, e.d);
            chk("stb_lat", cyc - rise_cyc, 3);
          end
        end
        if (d_oe && !oe_prev) begin
          if (rq.size() == 0) chk("unexp_oe", d_out, 0);
          else chk("rd_data", d_out, rq.pop_front());
        end
      end
      oe_prev = rst_n ? d_oe : 1'b0;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_icw", icw_stb, 0); chk("rst_ocw", ocw_stb, 0); chk("rst_wdata", wdata, 0);
    chk("rst_dout", d_out, 0); chk("rst_doe", d_oe, 0); chk("rst_done", init_done, 0);
    chk("rst_sngl", sngl, 1); chk("rst_ic4", ic4, 0); chk("rst_ltim", ltim, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    // single mode, no ICW4
    push_w(4'b0001, 0, 8'h12); wr(0, 8'h12);
    chk("t1_sngl", sngl, 1); chk("t1_ic4", ic4, 0); chk("t1_done0", init_done, 0);
    push_w(4'b0010, 0, 8'h20); wr(1, 8'h20);
    chk("t1_done1", init_done, 1);
    push_w(0, 3'b001, 8'hF0); wr(1, 8'hF0);
    // cascade with ICW4
    push_w(4'b0001, 0, 8'h11); wr(0, 8'h11);
    chk("t2_done0", init_done, 0); chk("t2_sngl", sngl, 0); chk("t2_ic4", ic4, 1);
    push_w(4'b0010, 0, 8'h40); wr(1, 8'h40);
    push_w(4'b0100, 0, 8'h04); wr(1, 8'h04);
    chk("t2_done_mid", init_done, 0);
    push_w(4'b1000, 0, 8'h01); wr(1, 8'h01);
    chk("t2_done1", init_done, 1);
    // read back and OCW decode
    rd(0, 8'hA5);
    push_w(0, 3'b100, 8'h0B); wr(0, 8'h0B);
    rd(0, 8'h3C);
    rd(1, 8'hF0);
    push_w(0, 3'b010, 8'h20); wr(0, 8'h20);
    push_w(0, 3'b100, 8'h0A); wr(0, 8'h0A);
    wr(0, 8'h88);
    chk("t4_wdata", wdata, 8'h0A);
    rd(0, 8'hA5);
    // vector priority during a read
    rq.push_back(8'hA5);
    @(negedge clk); cs_n = 0; a0 = 0;
    repeat (2) @(negedge clk); rd_n = 0;
    repeat (5) @(negedge clk); vec = 8'h47; vec_valid = 1; irr = 8'h5A;
    repeat (2) @(negedge clk);
    chk("t5_vec", d_out, 8'h47); chk("t5_vec_oe", d_oe, 1);
    vec_valid = 0;
    repeat (2) @(negedge clk);
    chk("t5_resume", d_out, 8'h5A); chk("t5_resume_oe", d_oe, 1);
    rd_n = 1;
    repeat (3) @(negedge clk);
    chk("t5_oe_off", d_oe, 0);
    cs_n = 1; irr = 8'hA5;
    repeat (3) @(negedge clk);
    rq.push_back(8'h47); vec_valid = 1;
    repeat (2) @(negedge clk); vec_valid = 0;
    repeat (2) @(negedge clk);
    chk("t5_idle_oe", d_oe, 0);
    // simultaneous read and write: read served, no strobe
    rq.push_back(8'hA5);
    @(negedge clk); cs_n = 0; a0 = 0; d_in = 8'h13;
    repeat (2) @(negedge clk); rd_n = 0; wr_n = 0;
    repeat (3) @(negedge clk); wr_n = 1;
    repeat (5) @(negedge clk); rd_n = 1;
    repeat (2) @(negedge clk); cs_n = 1;
    repeat (4) @(negedge clk);
    chk("t_rw_done", init_done, 1);
    // reset mid-sequence, drop in INIT_WAIT and in ICW2
    push_w(4'b0001, 0, 8'h11); wr(0, 8'h11);
    push_w(4'b0010, 0, 8'h40); wr(1, 8'h40);
    @(negedge clk); rst_n = 0;
    @(negedge clk);
    chk("t6_icw", icw_stb, 0); chk("t6_wdata", wdata, 0); chk("t6_done", init_done, 0);
    chk("t6_sngl", sngl, 1); chk("t6_ic4", ic4, 0); chk("t6_dout", d_out, 0); chk("t6_doe", d_oe, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    wr(1, 8'h55);
    chk("t6_drop_wdata", wdata, 0);
    push_w(4'b0001, 0, 8'h1B); wr(0, 8'h1B);
    chk("t6_ltim", ltim, 1); chk("t6_ic4b", ic4, 1);
    wr(0, 8'h00);
    push_w(4'b0010, 0, 8'h20); wr(1, 8'h20);
    chk("t6_done_mid", init_done, 0);
    push_w(4'b1000, 0, 8'h03); wr(1, 8'h03);
    chk("t6_done1", init_done, 1);
    repeat (5) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
